// File: rtl/regfile_sb.sv
// GPR file with per-register pending-write counters, multiple read/writeback
// ports and optional writeback-to-read forwarding.
module regfile_sb #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned NR_RD   = 2,
  parameter int unsigned NR_WB   = 2,
  parameter int unsigned CNT_W   = 2,
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b1,
  localparam int unsigned RW     = $clog2(NREG)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NR_RD*RW-1:0]     rs_i,
  output logic [NR_RD*XLEN-1:0]   src_o,
  output logic [NR_RD-1:0]        rdy_o,
  input  logic                    iss_valid_i,
  input  logic [RW-1:0]           iss_rd_i,
  output logic                    iss_ready_o,
  input  logic [NR_WB-1:0]        wb_valid_i,
  input  logic [NR_WB*RW-1:0]     wb_rd_i,
  input  logic [NR_WB*XLEN-1:0]   wb_data_i,
  input  logic [NR_WB-1:0]        wb_rel_i,
  output logic                    err_o
);

  localparam int unsigned DEC_W = $clog2(NR_WB + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [XLEN-1:0]  gpr_q   [NREG];
  logic [CNT_W-1:0] cnt_q   [NREG];
  logic [CNT_W-1:0] cnt_d   [NREG];
  logic [XLEN-1:0]  wr_data [NREG];
  logic [DEC_W-1:0] dec     [NREG];
  logic [31:0]      cnt_sum [NREG];
  logic [NREG-1:0]  wr_en;
  logic [NREG-1:0]  inc;
  logic [NREG-1:0]  uf;
  logic             err_q;

  // Registers that actually hold state (r0 may be hardwired, some codes may be unimplemented)
  function automatic logic live(input logic [RW-1:0] a);
    return (32'(a) < NREG) && !(ZERO_R0 && (a == '0));
  endfunction

  // Per-register write select (highest port wins) and release count
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      wr_en[r]   = 1'b0;
      wr_data[r] = '0;
      dec[r]     = '0;
      for (int j = 0; j < NR_WB; j++) begin
        if (wb_valid_i[j] && (wb_rd_i[j*RW +: RW] == RW'(r))) begin
          wr_en[r]   = 1'b1;
          wr_data[r] = wb_data_i[j*XLEN +: XLEN];
          if (wb_rel_i[j]) dec[r] = dec[r] + DEC_W'(1);
        end
      end
      if (ZERO_R0 && (r == 0)) begin
        wr_en[r] = 1'b0;
        dec[r]   = '0;
      end
    end
  end

  // A full counter still accepts an issue when a release frees a slot this cycle
  always_comb begin
    iss_ready_o = 1'b1;
    if (live(iss_rd_i))
      iss_ready_o = (cnt_q[iss_rd_i] != CNT_MAX) || (dec[iss_rd_i] != '0);
  end

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      inc[r] = iss_valid_i && iss_ready_o && (iss_rd_i == RW'(r));
      if (ZERO_R0 && (r == 0)) inc[r] = 1'b0;
    end
  end

  // Counter next state; excess releases clamp to zero and flag an error
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_sum[r] = 32'(cnt_q[r]) + 32'(inc[r]);
      uf[r]      = 1'b0;
      cnt_d[r]   = '0;
      if (32'(dec[r]) > cnt_sum[r]) uf[r] = 1'b1;
      else cnt_d[r] = CNT_W'(cnt_sum[r] - 32'(dec[r]));
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int r = 0; r < NREG; r++) begin
        gpr_q[r] <= '0;
        cnt_q[r] <= '0;
      end
      err_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (wr_en[r]) gpr_q[r] <= wr_data[r];
        cnt_q[r] <= cnt_d[r];
      end
      err_q <= err_q | (|uf);
    end
  end

  assign err_o = err_q;

  // Read ports: array value, optionally overridden by same-cycle writeback
  always_comb begin : c_read
    logic [RW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            r;
    src_o = '0;
    rdy_o = '1;
    for (int k = 0; k < NR_RD; k++) begin
      a = rs_i[k*RW +: RW];
      d = '0;
      r = 1'b1;
      if (live(a)) begin
        d = gpr_q[a];
        if (BYPASS) begin
          for (int j = 0; j < NR_WB; j++)
            if (wb_valid_i[j] && (wb_rd_i[j*RW +: RW] == a)) d = wb_data_i[j*XLEN +: XLEN];
          r = (32'(cnt_q[a]) <= 32'(dec[a]));
        end else begin
          r = (cnt_q[a] == '0);
        end
      end
      src_o[k*XLEN +: XLEN] = d;
      rdy_o[k]              = r;
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: stimulus pushes expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_regfile_sb;

  localparam int SEL_SRC0 = 0;
  localparam int SEL_SRC1 = 1;
  localparam int SEL_RDY  = 2;
  localparam int SEL_ISS  = 3;
  localparam int SEL_ERR  = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [9:0]  rs_i;
  logic [63:0] src_o;
  logic [1:0]  rdy_o;
  logic        iss_valid_i;
  logic [4:0]  iss_rd_i;
  logic        iss_ready_o;
  logic [1:0]  wb_valid_i;
  logic [9:0]  wb_rd_i;
  logic [63:0] wb_data_i;
  logic [1:0]  wb_rel_i;
  logic        err_o;

  regfile_sb dut (
    .clk_i(clk_i), .rst_i(rst_i), .rs_i(rs_i), .src_o(src_o), .rdy_o(rdy_o),
    .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
    .wb_valid_i(wb_valid_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i),
    .wb_rel_i(wb_rel_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  logic probe  = 1'b0;

  // Monitor: compares every queued expectation against the outputs of this cycle
  always @(negedge clk_i) begin
    if (probe) begin
      while (q.size() > 0) begin
        exp_t e;
        logic [31:0] got;
        e = q.pop_front();
        case (e.sel)
          SEL_SRC0: got = src_o[31:0];
          SEL_SRC1: got = src_o[63:32];
          SEL_RDY:  got = 32'(rdy_o);
          SEL_ISS:  got = 32'(iss_ready_o);
          default:  got = 32'(err_o);
        endcase
        checks++;
        if (got !== e.val) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, got, e.val);
        end
      end
    end
  end

  task automatic idle();
    rs_i = '0; iss_valid_i = 1'b0; iss_rd_i = '0;
    wb_valid_i = '0; wb_rd_i = '0; wb_data_i = '0; wb_rel_i = '0;
  endtask

  task automatic set_rs(input logic [4:0] a0, input logic [4:0] a1);
    rs_i = {a1, a0};
  endtask

  task automatic set_wb(input int j, input logic [4:0] rd, input logic [31:0] d, input logic rel);
    wb_valid_i[j]        = 1'b1;
    wb_rd_i[j*5 +: 5]    = rd;
    wb_data_i[j*32 +: 32] = d;
    wb_rel_i[j]          = rel;
  endtask

  task automatic set_iss(input logic [4:0] rd);
    iss_valid_i = 1'b1;
    iss_rd_i    = rd;
  endtask

  task automatic chk(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    q.push_back(e);
  endtask

  task automatic cyc();
    probe = 1'b1;
    @(posedge clk_i);
    #1;
    probe = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // T1: traffic under reset must leave no trace
    for (int i = 0; i < 2; i++) begin
      set_wb(0, 5'd5, 32'h0000_1234, 1'b1);
      set_iss(5'd7);
      set_rs(5'd6, 5'd8);
      chk("rst_src0", SEL_SRC0, 32'h0);
      chk("rst_rdy", SEL_RDY, 32'h3);
      chk("rst_iss", SEL_ISS, 32'h1);
      chk("rst_err", SEL_ERR, 32'h0);
      cyc();
    end
    rst_i = 1'b1;
    set_rs(5'd5, 5'd7);
    chk("post_rst_x5", SEL_SRC0, 32'h0);
    chk("post_rst_x7", SEL_SRC1, 32'h0);
    chk("post_rst_rdy", SEL_RDY, 32'h3);
    chk("post_rst_err", SEL_ERR, 32'h0);
    cyc();

    // T2: basic write, same-cycle bypass then array read
    set_wb(0, 5'd5, 32'hDEAD_BEEF, 1'b0);
    set_rs(5'd5, 5'd0);
    chk("t2_bypass", SEL_SRC0, 32'hDEAD_BEEF);
    cyc();
    set_rs(5'd5, 5'd0);
    chk("t2_read", SEL_SRC0, 32'hDEAD_BEEF);
    chk("t2_rdy", SEL_RDY, 32'h3);
    cyc();

    // T3: two reservations on x7, released one at a time
    set_iss(5'd7); set_rs(5'd7, 5'd0);
    chk("t3_iss1", SEL_ISS, 32'h1);
    chk("t3_rdy_c0", SEL_RDY, 32'h3);
    cyc();
    set_iss(5'd7); set_rs(5'd7, 5'd0);
    chk("t3_iss2", SEL_ISS, 32'h1);
    chk("t3_rdy_c1", SEL_RDY, 32'h2);
    cyc();
    set_rs(5'd7, 5'd0);
    chk("t3_rdy_c2", SEL_RDY, 32'h2);
    cyc();
    set_wb(0, 5'd7, 32'h0000_AAAA, 1'b1); set_rs(5'd7, 5'd0);
    chk("t3_rel1_rdy", SEL_RDY, 32'h2);
    chk("t3_rel1_src", SEL_SRC0, 32'h0000_AAAA);
    cyc();
    set_wb(1, 5'd7, 32'h5555_0007, 1'b1); set_rs(5'd7, 5'd0);
    chk("t3_rel2_rdy", SEL_RDY, 32'h3);
    chk("t3_rel2_src", SEL_SRC0, 32'h5555_0007);
    cyc();
    set_rs(5'd7, 5'd0);
    chk("t3_final_src", SEL_SRC0, 32'h5555_0007);
    chk("t3_final_rdy", SEL_RDY, 32'h3);
    cyc();

    // T4: saturation of x3
    for (int i = 0; i < 3; i++) begin
      set_iss(5'd3);
      chk("t4_fill_iss", SEL_ISS, 32'h1);
      cyc();
    end
    set_iss(5'd3); set_rs(5'd3, 5'd0);
    chk("t4_full_iss", SEL_ISS, 32'h0);
    chk("t4_full_rdy", SEL_RDY, 32'h2);
    cyc();
    set_iss(5'd3); set_wb(0, 5'd3, 32'h0000_0033, 1'b1); set_rs(5'd3, 5'd0);
    chk("t4_net_iss", SEL_ISS, 32'h1);
    chk("t4_net_rdy", SEL_RDY, 32'h2);
    cyc();
    set_iss(5'd3); set_rs(5'd3, 5'd0);
    chk("t4_still_full", SEL_ISS, 32'h0);
    chk("t4_still_rdy", SEL_RDY, 32'h2);
    cyc();
    set_wb(0, 5'd3, 32'h0000_0066, 1'b1); set_wb(1, 5'd3, 32'h0000_0066, 1'b1);
    set_rs(5'd3, 5'd0);
    chk("t4_dual_rel_rdy", SEL_RDY, 32'h2);
    cyc();
    set_wb(0, 5'd3, 32'h0000_0077, 1'b1); set_rs(5'd3, 5'd0);
    chk("t4_last_rel_rdy", SEL_RDY, 32'h3);
    chk("t4_last_rel_src", SEL_SRC0, 32'h0000_0077);
    cyc();
    set_rs(5'd3, 5'd0);
    chk("t4_drained_src", SEL_SRC0, 32'h0000_0077);
    chk("t4_drained_err", SEL_ERR, 32'h0);
    cyc();

    // T5: both writeback ports hit x9, port 1 wins
    set_wb(0, 5'd9, 32'h1, 1'b0); set_wb(1, 5'd9, 32'h2, 1'b0); set_rs(5'd9, 5'd9);
    chk("t5_byp0", SEL_SRC0, 32'h2);
    chk("t5_byp1", SEL_SRC1, 32'h2);
    cyc();
    set_rs(5'd9, 5'd0);
    chk("t5_array", SEL_SRC0, 32'h2);
    cyc();

    // T6: r0 hardwired, underflow on x4
    set_wb(0, 5'd0, 32'h0000_FFFF, 1'b1); set_rs(5'd0, 5'd0);
    chk("t6_r0_byp", SEL_SRC0, 32'h0);
    chk("t6_r0_rdy", SEL_RDY, 32'h3);
    cyc();
    set_rs(5'd0, 5'd0);
    chk("t6_r0_read", SEL_SRC0, 32'h0);
    chk("t6_r0_rel_err", SEL_ERR, 32'h0);
    cyc();
    set_wb(0, 5'd4, 32'h0000_0044, 1'b1);
    chk("t6_uf_err_pre", SEL_ERR, 32'h0);
    cyc();
    set_rs(5'd4, 5'd0);
    chk("t6_uf_err", SEL_ERR, 32'h1);
    chk("t6_uf_rdy", SEL_RDY, 32'h3);
    chk("t6_uf_data", SEL_SRC0, 32'h0000_0044);
    cyc();
    set_iss(5'd4);
    chk("t6_iss_after_uf", SEL_ISS, 32'h1);
    cyc();
    set_rs(5'd4, 5'd0);
    chk("t6_cnt1_rdy", SEL_RDY, 32'h2);
    chk("t6_err_sticky", SEL_ERR, 32'h1);
    cyc();

    // Reset mid-operation discards the reservation on x4 and the sticky error
    rst_i = 1'b0;
    set_rs(5'd4, 5'd5);
    chk("midrst_rdy", SEL_RDY, 32'h3);
    chk("midrst_err", SEL_ERR, 32'h0);
    chk("midrst_x5", SEL_SRC1, 32'h0);
    cyc();
    rst_i = 1'b1;
    set_rs(5'd4, 5'd0);
    chk("after_midrst_rdy", SEL_RDY, 32'h3);
    cyc();

    @(negedge clk_i);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d left expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
